// File: rtl/video_cmd_splitter.sv
// Splits a byte-addressed transfer command into mover commands that never
// cross a BOUNDARY-aligned address, one packed 64-bit chunk word per handshake.
`timescale 1ns/1ps
module video_cmd_splitter #(
  parameter int BOUNDARY = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [38:0] cmd_addr,
  input  logic [31:0] cmd_len,
  input  logic [2:0]  cmd_dest,
  input  logic [7:0]  cmd_user,
  input  logic        cmd_last,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int          B_U     = BOUNDARY / 64;
  localparam logic [25:0] B_UNITS = 26'(B_U);
  localparam logic [25:0] B_MASK  = 26'(B_U - 1);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t      state, state_nxt;
  logic [32:0] addr_u;
  logic [25:0] rem_u;
  logic [2:0]  dest_r;
  logic [7:0]  user_r;
  logic        last_r;

  logic        cmd_fire;
  logic        out_fire;
  logic [25:0] cmd_units;
  logic [25:0] to_bnd_u;
  logic [25:0] chunk_u;
  logic        final_chunk;
  logic        unused_lsbs;

  // Distance in 64-byte units from addr to the next boundary (1..B_U).
  function automatic logic [25:0] units_to_boundary(input logic [25:0] a_lo);
    return B_UNITS - (a_lo & B_MASK);
  endfunction

  function automatic logic [25:0] min_units(input logic [25:0] a,
                                            input logic [25:0] b);
    return (a < b) ? a : b;
  endfunction

  assign unused_lsbs = ^{cmd_addr[5:0], cmd_len[5:0]};

  assign cmd_units   = cmd_len[31:6];
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state == SPLIT);
  assign out_valid   = busy;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign out_fire    = out_valid && out_ready;

  assign to_bnd_u    = units_to_boundary(addr_u[25:0]);
  assign chunk_u     = min_units(rem_u, to_bnd_u);
  assign final_chunk = (rem_u <= to_bnd_u);

  // Chunk length fits 15 bits: a chunk never exceeds B_U <= 16384 units.
  // Gating with busy keeps the word at zero out of reset and between commands.
  assign out_data = busy ? {user_r, last_r & final_chunk, chunk_u[14:0], 1'b0,
                            addr_u, 3'b000, dest_r}
                         : 64'd0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire && (cmd_units != 26'd0)) begin
          state_nxt = SPLIT;
        end
      end
      SPLIT: begin
        if (out_fire && final_chunk) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address advances modulo 2^33 units, so splitting continues from 0 on wrap.
  always_ff @(posedge aclk) begin
    if (cmd_fire) begin
      addr_u <= cmd_addr[38:6];
      rem_u  <= cmd_units;
      dest_r <= cmd_dest;
      user_r <= cmd_user;
      last_r <= cmd_last;
    end else if (out_fire) begin
      addr_u <= addr_u + {7'd0, chunk_u};
      rem_u  <= rem_u - chunk_u;
    end
  end

endmodule

// File: tb/tb_video_cmd_splitter.sv
// Directed bench for video_cmd_splitter: a byte-level chunk model checked every
// cycle, plus hand-computed chunk words for the called-out scenarios.
`timescale 1ns/1ps
module tb_video_cmd_splitter;

  localparam int BOUNDARY = 4096;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [38:0] cmd_addr;
  logic [31:0] cmd_len;
  logic [2:0]  cmd_dest;
  logic [7:0]  cmd_user;
  logic        cmd_last;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [63:0] exp_q[$];

  video_cmd_splitter #(.BOUNDARY(BOUNDARY)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_dest  (cmd_dest),
    .cmd_user  (cmd_user),
    .cmd_last  (cmd_last),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-level reference: walk the transfer, cutting at every BOUNDARY multiple.
  function automatic void model_push(input logic [38:0] a, input logic [31:0] l,
                                     input logic [2:0] d, input logic [7:0] u,
                                     input logic lst);
    longint unsigned addr, rem, n;
    logic [32:0] au;
    logic [14:0] nu;
    logic        lb;
    addr = {25'd0, a} & ~64'd63;
    rem  = {32'd0, l} & ~64'd63;
    while (rem != 0) begin
      n = 64'(BOUNDARY) - (addr % 64'(BOUNDARY));
      if (n > rem) n = rem;
      au = addr[38:6];
      nu = 15'(n / 64);
      lb = (n == rem) && lst;
      exp_q.push_back({u, lb, nu, 1'b0, au, 3'b000, d});
      addr = (addr + n) % (64'd1 << 39);
      rem  = rem - n;
    end
  endfunction

  always @(posedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (cmd_valid && cmd_ready) model_push(cmd_addr, cmd_len, cmd_dest, cmd_user, cmd_last);
    end
  end

  always @(negedge aclk) begin
    if (chk_en) begin
      chk64("inv_out_valid", out_valid, exp_q.size() != 0);
      chk64("inv_busy", busy, exp_q.size() != 0);
      chk64("inv_cmd_ready", cmd_ready, exp_q.size() == 0);
      if (exp_q.size() != 0) chk64("inv_out_data", out_data, exp_q[0]);
    end
  end

  task automatic send_cmd(input logic [38:0] a, input logic [31:0] l, input logic [2:0] d,
                          input logic [7:0] u, input logic lst);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk64("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_dest  = d;
    cmd_user  = u;
    cmd_last  = lst;
    cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_chunk(input string name, input logic [63:0] lit);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk64({name, "_valid"}, out_valid, 1'b1);
    chk64(name, out_data, lit);
    @(negedge aclk);
  endtask

  initial begin
    aresetn   = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_dest  = '0;
    cmd_user  = '0;
    cmd_last  = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk_en = 1'b1;
    chk64("rst_out_valid", out_valid, 1'b0);
    chk64("rst_busy", busy, 1'b0);
    chk64("rst_cmd_ready", cmd_ready, 1'b1);
    chk64("rst_out_data", out_data, 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Three aligned full chunks, last bit only on the third
    send_cmd(39'h10_00, 32'h3000, 3'd2, 8'h5A, 1'b1);
    expect_chunk("r028_c1", 64'h5A00_4000_0000_1002);
    expect_chunk("r028_c2", 64'h5A00_4000_0000_2002);
    expect_chunk("r028_c3", 64'h5A80_4000_0000_3002);
    chk64("r028_done", out_valid, 1'b0);

    // Unaligned start: one unit up to the boundary, then the remainder
    send_cmd(39'h0F_C0, 32'h100, 3'd5, 8'h11, 1'b0);
    expect_chunk("r029_c1", 64'h1100_0100_0000_0FC5);
    expect_chunk("r029_c2", 64'h1100_0300_0000_1005);
    chk64("r029_done", out_valid, 1'b0);

    // Sub-unit length: accepted, nothing emitted
    send_cmd(39'h20_00, 32'h20, 3'd0, 8'h00, 1'b1);
    chk64("r030_valid", out_valid, 1'b0);
    chk64("r030_ready", cmd_ready, 1'b1);
    chk64("r030_busy", busy, 1'b0);

    // Back-pressure for 5 cycles on chunk 2 with a competing command offered
    send_cmd(39'h0, 32'h3000, 3'd1, 8'h44, 1'b0);
    expect_chunk("r031_c1", 64'h4400_4000_0000_0001);
    out_ready = 1'b0;
    cmd_addr  = 39'h5_0000;
    cmd_len   = 32'h40;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk64("r031_hold_valid", out_valid, 1'b1);
      chk64("r031_hold_data", out_data, 64'h4400_4000_0000_1001);
      chk64("r031_no_accept", cmd_ready, 1'b0);
      @(negedge aclk);
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    expect_chunk("r031_c2", 64'h4400_4000_0000_1001);
    expect_chunk("r031_c3", 64'h4400_4000_0000_2001);
    chk64("r031_done", out_valid, 1'b0);

    // Address wrap at 2^39
    send_cmd(39'h7F_FFFF_F000, 32'h2000, 3'd7, 8'h33, 1'b1);
    expect_chunk("r032_c1", 64'h3300_407F_FFFF_F007);
    expect_chunk("r032_c2", 64'h3380_4000_0000_0007);
    chk64("r032_done", out_valid, 1'b0);

    // Reset during the second chunk abandons the split
    send_cmd(39'h1_0000, 32'h3000, 3'd3, 8'h66, 1'b1);
    expect_chunk("r033_c1", 64'h6600_4000_0001_0003);
    chk64("r033_c2_pre", out_data, 64'h6600_4000_0001_1003);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    chk64("r033_valid", out_valid, 1'b0);
    chk64("r033_busy", busy, 1'b0);
    chk64("r033_ready", cmd_ready, 1'b1);
    chk64("r033_data", out_data, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk64("r033_quiet", out_valid, 1'b0);
    end

    // Unaligned multi-chunk with intermittent out_ready (51, 64, 54 units)
    send_cmd(39'h1_2340, 32'h2A40, 3'd6, 8'hC3, 1'b1);
    for (int i = 0; i < 60 && !cmd_ready; i++) begin
      out_ready = (i % 3) != 1;
      @(negedge aclk);
    end
    out_ready = 1'b1;
    chk64("mix_drained", cmd_ready, 1'b1);
    chk64("mix_model_empty", exp_q.size(), 64'd0);

    repeat (2) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_cmd_splitter.md
VIDEO_CMD_SPLITTER -- requirements
Module: video_cmd_splitter

Interface
REQ-001 SHALL have parameter BOUNDARY, default 4096: chunk size and alignment boundary in bytes; power of two, 64..1048576.
REQ-002 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_addr  input  39  start byte address; bits [5:0] ignored.
REQ-005 SHALL have port cmd_len  input  32  transfer length in bytes; bits [5:0] ignored.
REQ-006 SHALL have port cmd_dest  input  3  stream destination, copied to every chunk.
REQ-007 SHALL have port cmd_user  input  8  user tag, copied to every chunk.
REQ-008 SHALL have port cmd_last  input  1  end-of-job flag for the final chunk.
REQ-009 SHALL have ports cmd_valid  input  1  and cmd_ready  output  1  command handshake.
REQ-010 SHALL have port out_data  output  64  packed mover command word.
REQ-011 SHALL have ports out_valid  output  1  and out_ready  input  1  chunk handshake.
REQ-012 SHALL have port busy  output  1  high while a command is being split.

Function
REQ-013 SHALL pack out_data as [63:56] user, [55] last, [54:40] len in 64-byte units, [39] 0, [38:6] addr[38:6], [5:3] 0, [2:0] dest.
REQ-014 SHALL implement two states, IDLE and SPLIT; cmd_ready = (state == IDLE); busy = (state == SPLIT).
REQ-015 SHALL, on a cmd handshake, latch addr units (33 bits), remaining units = cmd_len[31:6], dest, user and last.
REQ-016 SHALL stay in IDLE, with no chunk emitted, when the accepted command has zero remaining units.
REQ-017 SHALL otherwise enter SPLIT and assert out_valid on the cycle after the handshake, with the first chunk on out_data.
REQ-018 SHALL compute chunk units as min(remaining, B - (addr mod B)), where B = BOUNDARY/64; no chunk crosses a BOUNDARY-aligned address.
REQ-019 SHALL set the last bit only on the final chunk of a command, and only if the latched cmd_last is 1.
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, on each out handshake, advance addr by the chunk units and decrement remaining by the chunk units.
REQ-022 SHALL present the next chunk on the following cycle with no bubble; one chunk per cycle under continuous out_ready.
REQ-023 SHALL, on the handshake of the final chunk, drop out_valid and return to IDLE; the next command is accepted no earlier than the following cycle.
REQ-024 SHALL wrap addr units modulo 2^33 (byte address modulo 2^39) and continue splitting from address 0.
REQ-025 SHALL ignore cmd_valid while in SPLIT; commands are never dropped or merged.

Reset
REQ-026 SHALL, while aresetn = 0 at a clock edge, set state IDLE, out_valid 0, busy 0, cmd_ready 1 from the next cycle, and out_data 0.
REQ-027 SHALL abandon any in-progress split on reset; no partial chunk is emitted after reset release.

Verification
REQ-028 SHALL test: addr 0x1000, len 0x3000, dest 2, user 0x5A, last 1, out_ready 1 -> 3 consecutive chunks at 0x1000/0x2000/0x3000, each len 64 units, last bit only on the 3rd.
REQ-029 SHALL test: addr 0x0FC0, len 0x100, last 0 -> chunk addr 0x0FC0 len 1, then addr 0x1000 len 3, both last 0.
REQ-030 SHALL test: len 0x20 (zero units) -> handshake completes, out_valid stays 0, cmd_ready 1 the next cycle.
REQ-031 SHALL test: out_ready held 0 for 5 cycles mid-command -> out_data/out_valid unchanged all 5 cycles; a new cmd_valid is not accepted.
REQ-032 SHALL test: addr 0x7F_FFFF_F000, len 0x2000 -> chunks at 0x7F_FFFF_F000 and 0x0, each len 64 units.
REQ-033 SHALL test: aresetn low for 1 cycle during the 2nd chunk of a 3-chunk command -> out_valid 0 and busy 0 the next cycle, cmd_ready 1, no further chunks.
